fsq_arbiter: RTL and testbench
==============================

# fsq_arbiter

Round-robin arbiter and sequencer that shares one floating-point squaring unit between N requesters. It sits between the requesting blocks and the single squaring unit, which has a start/done handshake (x, r_i, res, err, r_o). The arbiter:
- latches the winner's operand and pulses the unit's start;
- waits for the unit's done, bounded by a watchdog;
- returns result, error and timeout flag to the winner with a one-cycle done pulse.

## Interface
- N, 4, number of requesters (2..8)
- TIMEOUT, 16, max cycles in WAIT before forced completion (2..255)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_i  in  N  request per requester, level; held until ack_o bit seen
- x_i  in  32*N  operands, flat; requester k on bits [32k+31:32k], IEEE-754 single
- ack_o  out  N  one-cycle pulse: operand of requester k captured
- done_o  out  N  one-cycle pulse: result for requester k valid
- res_o  out  32  result, shared bus, valid from done pulse until next done pulse
- err_o  out  1  unit error flag for res_o (forced 1 on timeout)
- tmo_o  out  1  1 = result produced by watchdog, not by unit
- tmo_cnt_o  out  8  count of timeouts since reset, saturates at 255
- busy_o  out  1  state != IDLE
- u_x  out  32  operand to unit, held stable from ISSUE through end of WAIT
- u_start  out  1  start pulse to unit (one cycle)
- u_res  in  32  unit result
- u_err  in  1  unit error/overflow flag
- u_done  in  1  unit done pulse, one cycle

## Operation
- Reset (async, rst_n=0): state IDLE, pointer 0, timer 0, winner 0. All outputs 0, including u_x, res_o and tmo_cnt_o.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_i is sampled only in this state.
  - If any bit is set, the winner w is the first set bit searching upward from the pointer, modulo N.
  - On that edge: u_x <= x_i[w], ack_o[w] <= 1, pointer <= (w+1) mod N, state -> ISSUE.
  - If req_i == 0, stay in IDLE.
- ISSUE: u_start = 1 for this cycle only; timer <= 0; -> WAIT.
- WAIT:
  - If u_done=1: res_o <= u_res, err_o <= u_err, tmo_o <= 0; -> RESP.
  - Else if timer == TIMEOUT-1: res_o <= 0, err_o <= 1, tmo_o <= 1, tmo_cnt_o increments (saturating); -> RESP.
  - Else timer increments.
  - If u_done arrives in the same cycle as the timeout, the done takes priority and no timeout is recorded.
- RESP: done_o[w] = 1 for this cycle; -> IDLE.
- u_done outside WAIT is ignored. This covers a late done after a timeout.
- At most one ack_o bit and one done_o bit are set in any cycle. ack_o and done_o are never high together.
- Requesters drop req_i in the cycle after ack_o. A request still high when the arbiter returns to IDLE is treated as a new request.
- A request that rises during ISSUE, WAIT or RESP waits until the next IDLE. No request is lost while it is held high.
- Fairness: with all N requesting continuously, grants rotate 0,1,..,N-1,0,...
- res_o, err_o and tmo_o hold their last values until overwritten.

## Timing
- All outputs are registered. u_start is a decode of state == ISSUE. busy_o is a decode of state != IDLE.
- Request sampled at edge k (IDLE):
  - ack_o and state ISSUE at cycle k+1;
  - u_start high during cycle k+1;
  - WAIT from cycle k+2.
- u_done high in cycle d (WAIT): done_o high and outputs valid in cycle d+1 (RESP); IDLE in cycle d+2.
- Minimum transaction: 4 cycles plus unit latency. With unit latency L (start to done), total is L+3 cycles from the IDLE sample edge to RESP.
- Timeout: with no done, RESP is entered TIMEOUT cycles after WAIT entry.
- Reset mid-transaction: immediate return to IDLE. Any u_done already pending is ignored. No done_o is issued for the aborted request.

## Test plan
- Single request, unit model with latency 5: requester 2 sends x=0x40400000 (3.0), unit returns 0x41100000.
  - Required: ack_o=0100 one cycle later, u_x=0x40400000, one u_start pulse.
  - Required: done_o=0100 eight cycles after the sample edge, res_o=0x41100000, err_o=0, tmo_o=0.
- All four requesters held high, with x = 2.0 / 1.5 / 3.0 / 1.0 (0x40000000 / 0x3FC00000 / 0x40400000 / 0x3F800000).
  - Required grant order 0,1,2,3,0.
  - Required results 0x40800000, 0x40100000, 0x41100000, 0x3F800000, each on the matching done_o bit.
- Unit never asserts done, TIMEOUT=16: done_o for the winner with res_o=0, err_o=1, tmo_o=1, tmo_cnt_o=1. A u_done injected two cycles later is ignored (no done_o, state stays IDLE).
- u_done in the same cycle as the last timeout cycle: tmo_o=0, tmo_cnt_o unchanged, res_o=u_res.
- Unit returns u_err=1 (overflow) for x=0x7F000000: err_o=1, tmo_o=0.
- rst_n pulled low during WAIT, then released: all outputs 0 asynchronously; no done_o for the aborted request; the next request is granted starting from pointer 0.

Source files
------------

// File: rtl/fsq_arbiter.sv
// fsq_arbiter: round-robin sequencer sharing one FP squaring unit
// among N requesters, with a watchdog on the unit's done pulse.
module fsq_arbiter #(
   parameter int N       = 4,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req_i,
   input  logic [32*N-1:0] x_i,
   output logic [N-1:0]    ack_o,
   output logic [N-1:0]    done_o,
   output logic [31:0]     res_o,
   output logic            err_o,
   output logic            tmo_o,
   output logic [7:0]      tmo_cnt_o,
   output logic            busy_o,
   output logic [31:0]     u_x,
   output logic            u_start,
   input  logic [31:0]     u_res,
   input  logic            u_err,
   input  logic            u_done
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]    state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic [PW-1:0] pick;
   logic          any_req;
   logic [7:0]    timer;
   int            idx;

   // winner: first set request at or above the pointer, wrapping
   always_comb begin
      pick    = ptr;
      any_req = 1'b0;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!any_req && req_i[idx]) begin
            any_req = 1'b1;
            pick    = PW'(idx);
         end
      end
   end

   // ack and done are one-hot decodes of the latched winner
   always_comb begin
      ack_o  = '0;
      done_o = '0;
      for (int k = 0; k < N; k++) begin
         ack_o[k]  = (state == S_ISSUE) && (win == PW'(k));
         done_o[k] = (state == S_RESP) && (win == PW'(k));
      end
   end

   assign u_start = (state == S_ISSUE);
   assign busy_o  = (state != S_IDLE);

   // sequencer: grant, issue, wait with watchdog, respond
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         ptr       <= '0;
         win       <= '0;
         timer     <= '0;
         u_x       <= '0;
         res_o     <= '0;
         err_o     <= 1'b0;
         tmo_o     <= 1'b0;
         tmo_cnt_o <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (any_req) begin
                  win   <= pick;
                  u_x   <= x_i[32*int'(pick) +: 32];
                  ptr   <= (int'(pick) == N-1) ? '0 : pick + 1'b1;
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               timer <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (u_done) begin
                  res_o <= u_res;
                  err_o <= u_err;
                  tmo_o <= 1'b0;
                  state <= S_RESP;
               end else if (timer == 8'(TIMEOUT-1)) begin
                  res_o <= '0;
                  err_o <= 1'b1;
                  tmo_o <= 1'b1;
                  if (tmo_cnt_o != 8'hFF)
                     tmo_cnt_o <= tmo_cnt_o + 8'd1;
                  state <= S_RESP;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fsq_arbiter.sv
// tb_fsq_arbiter: vector table, corner sequences and randomized
// transactions against a transaction-level model of the arbiter.
module tb_fsq_arbiter;

   localparam int N = 4;
   localparam int T = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   req_i = '0;
   logic [127:0] x_i = '0;
   logic [3:0]   ack_o;
   logic [3:0]   done_o;
   logic [31:0]  res_o;
   logic         err_o;
   logic         tmo_o;
   logic [7:0]   tmo_cnt_o;
   logic         busy_o;
   logic [31:0]  u_x;
   logic         u_start;
   logic [31:0]  u_res = '0;
   logic         u_err = 1'b0;
   logic         u_done = 1'b0;

   int checks = 0;
   int failures = 0;
   int mptr = 0;
   int mtmo = 0;
   int ulat = 0;
   bit uerr_v = 1'b0;
   bit inject = 1'b0;
   int ucnt = 0;
   logic [31:0] ux_l = '0;

   localparam logic [127:0] DFLT =
      {32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h40000000};

   fsq_arbiter #(.N(N), .TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .x_i(x_i),
      .ack_o(ack_o), .done_o(done_o), .res_o(res_o),
      .err_o(err_o), .tmo_o(tmo_o), .tmo_cnt_o(tmo_cnt_o),
      .busy_o(busy_o), .u_x(u_x), .u_start(u_start),
      .u_res(u_res), .u_err(u_err), .u_done(u_done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] unit_f(input logic [31:0] x);
      case (x)
         32'h40000000: return 32'h40800000;
         32'h3FC00000: return 32'h40100000;
         32'h40400000: return 32'h41100000;
         32'h3F800000: return 32'h3F800000;
         32'h7F000000: return 32'h7F800000;
         default:      return x ^ 32'hA5A50F0F;
      endcase
   endfunction

   // squaring unit model: done pulse ulat edges after seeing start
   always @(posedge clk) begin
      u_done <= 1'b0;
      if (u_start) begin
         ucnt <= ulat;
         ux_l <= u_x;
      end else if (ucnt > 0) begin
         ucnt <= ucnt - 1;
         if (ucnt == 1) begin
            u_done <= 1'b1;
            u_res  <= unit_f(ux_l);
            u_err  <= uerr_v;
         end
      end
      if (inject) u_done <= 1'b1;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic int pick_m(input logic [3:0] m, input int p);
      for (int i = 0; i < N; i++)
         if (m[(p + i) % N]) return (p + i) % N;
      return -1;
   endfunction

   task automatic chk_zero(input string nm);
      chk({nm, " ack"}, 32'(ack_o), 0);
      chk({nm, " done"}, 32'(done_o), 0);
      chk({nm, " res"}, res_o, 0);
      chk({nm, " err"}, 32'(err_o), 0);
      chk({nm, " tmo"}, 32'(tmo_o), 0);
      chk({nm, " tcnt"}, 32'(tmo_cnt_o), 0);
      chk({nm, " busy"}, 32'(busy_o), 0);
      chk({nm, " ux"}, u_x, 0);
      chk({nm, " start"}, 32'(u_start), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_i = '0;
      inject = 1'b0;
      #12;
      chk_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
      mptr = 0;
      mtmo = 0;
   endtask

   task automatic do_txn(input logic [3:0] mask, input bit drop,
                         input int lat, input bit uerr,
                         input logic [127:0] xv, input int ew,
                         input logic [31:0] eres, input bit eerr,
                         input bit etmo, input string nm);
      int ed;
      bit early;
      @(negedge clk);
      req_i = mask;
      x_i = xv;
      ulat = lat;
      uerr_v = uerr;
      @(posedge clk);
      #1;
      chk({nm, " ack"}, 32'(ack_o), 32'(1) << ew);
      chk({nm, " ux"}, u_x, xv[32*ew +: 32]);
      chk({nm, " start"}, 32'(u_start), 1);
      mptr = (ew + 1) % N;
      @(negedge clk);
      if (drop) req_i[ew] = 1'b0;
      ed = (lat >= 1 && lat <= T-1) ? lat + 2 : T + 1;
      early = 1'b0;
      for (int e = 1; e <= ed; e++) begin
         @(posedge clk);
         #1;
         if (e < ed && (done_o != 0 || ack_o != 0 || u_start))
            early = 1'b1;
      end
      if (etmo && mtmo < 255) mtmo++;
      chk({nm, " quiet"}, 32'(early), 0);
      chk({nm, " done"}, 32'(done_o), 32'(1) << ew);
      chk({nm, " ack0"}, 32'(ack_o), 0);
      chk({nm, " res"}, res_o, eres);
      chk({nm, " err"}, 32'(err_o), 32'(eerr));
      chk({nm, " tmo"}, 32'(tmo_o), 32'(etmo));
      chk({nm, " tcnt"}, 32'(tmo_cnt_o), 32'(mtmo));
      @(posedge clk);
      #1;
      chk({nm, " idle"}, 32'(busy_o), 0);
      chk({nm, " done0"}, 32'(done_o), 0);
   endtask

   typedef struct {
      logic [3:0]  mask;
      int          lat;
      bit          uerr;
      logic [31:0] op;
      int          ew;
      logic [31:0] eres;
      bit          eerr;
      bit          etmo;
      string       nm;
   } vec_t;

   task automatic run_table();
      vec_t v[6];
      logic [127:0] xv;
      v[0] = '{4'b0100, 5, 0, 32'h40400000, 2, 32'h41100000, 0, 0, "single"};
      v[1] = '{4'b0001, 3, 1, 32'h7F000000, 0, 32'h7F800000, 1, 0, "ovf"};
      v[2] = '{4'b0010, 0, 0, 32'h3FC00000, 1, 32'h0, 1, 1, "tmo"};
      v[3] = '{4'b0001, T-1, 0, 32'h40000000, 0, 32'h40800000, 0, 0, "tie"};
      v[4] = '{4'b1001, T, 0, 32'h3F800000, 3, 32'h0, 1, 1, "late"};
      v[5] = '{4'b1111, 1, 0, 32'h3F800000, 0, 32'h3F800000, 0, 0, "min"};
      for (int i = 0; i < 6; i++) begin
         xv = DFLT;
         xv[32*v[i].ew +: 32] = v[i].op;
         do_txn(v[i].mask, 1'b1, v[i].lat, v[i].uerr, xv, v[i].ew,
                v[i].eres, v[i].eerr, v[i].etmo, v[i].nm);
      end
      @(negedge clk);
      req_i = '0;
   endtask

   task automatic run_late_done();
      do_txn(4'b0100, 1'b1, 0, 1'b0, DFLT, 2, 32'h0, 1'b1, 1'b1, "tmo2");
      @(negedge clk);
      inject = 1'b1;
      @(negedge clk);
      inject = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk("stray done", 32'(done_o), 0);
         chk("stray busy", 32'(busy_o), 0);
      end
   endtask

   task automatic run_rr();
      logic [31:0] r;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         r = unit_f(DFLT[32*(i%N) +: 32]);
         do_txn(4'b1111, 1'b0, 4, 1'b0, DFLT, i % N, r, 1'b0, 1'b0, "rr");
      end
      @(negedge clk);
      req_i = '0;
   endtask

   task automatic run_reset_mid();
      do_reset();
      @(negedge clk);
      req_i = 4'b0100;
      x_i = DFLT;
      ulat = 8;
      @(posedge clk);
      @(negedge clk);
      req_i = '0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("rst mid");
      @(negedge clk);
      rst_n = 1'b1;
      mptr = 0;
      mtmo = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("abort done", 32'(done_o), 0);
         chk("abort busy", 32'(busy_o), 0);
      end
      do_txn(4'b1010, 1'b1, 2, 1'b0, DFLT, 1,
             unit_f(DFLT[63:32]), 1'b0, 1'b0, "post rst");
   endtask

   task automatic run_random();
      logic [3:0]   m;
      logic [127:0] xv;
      logic [31:0]  er;
      int w, lat;
      bit ue, ee, et;
      for (int t = 0; t < 120; t++) begin
         m = req_i | 4'($urandom_range(0, 15));
         if (m == 0) m = 4'(1 << $urandom_range(0, 3));
         for (int k = 0; k < N; k++)
            xv[32*k +: 32] = ($urandom_range(0, 3) == 0) ?
                             DFLT[32*k +: 32] : $urandom;
         w = pick_m(m, mptr);
         lat = $urandom_range(0, T + 4);
         ue = 1'($urandom_range(0, 1));
         if (lat >= 1 && lat <= T-1) begin
            er = unit_f(xv[32*w +: 32]);
            ee = ue;
            et = 1'b0;
         end else begin
            er = '0;
            ee = 1'b1;
            et = 1'b1;
         end
         do_txn(m, 1'($urandom_range(0, 1)), lat, ue, xv, w,
                er, ee, et, "rnd");
      end
      @(negedge clk);
      req_i = '0;
   endtask

   task automatic run_saturate();
      do_reset();
      for (int i = 0; i < 257; i++)
         do_txn(4'b0001, 1'b1, 0, 1'b0, DFLT, 0, 32'h0,
                1'b1, 1'b1, "sat");
   endtask

   initial begin
      do_reset();
      run_table();
      run_late_done();
      run_rr();
      run_reset_mid();
      run_random();
      run_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
